// File: rtl/rom_loader_pkg.sv
// Types and constants for the UART program loader.
`include "rom_loader_defines.svh"

package rom_loader_pkg;

    localparam logic [7:0]  HDR_BYTE = `RL_HDR_BYTE;
    localparam logic [31:0] NOP_WORD = `RL_NOP_WORD;

    typedef enum logic [1:0] {
        WAIT_HDR,
        GET_COUNT,
        GET_DATA,
        RUN
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // A count byte of 0 means 256 words, which the 8-bit wrap of n - 1 gives for free.
    function automatic logic is_last_word(input logic [7:0] ptr, input logic [7:0] n);
        return ptr == 8'(n - 8'd1);
    endfunction

endpackage

// File: rtl/rom_loader_defines.svh
// Constants shared by the loader RTL, the host-side image tool and the bench.
`ifndef ROM_LOADER_DEFINES_SVH
`define ROM_LOADER_DEFINES_SVH

`define RL_HDR_BYTE 8'hA5
`define RL_NOP_WORD 32'h00000013

`endif

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronised input, mid-bit sampling, one-cycle byte/error strobes.
module uart_rx
    import rom_loader_pkg::*;
#(
    parameter int BIT_TICKS = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       stop_error
);

    localparam int HALF_TICKS = (BIT_TICKS / 2 > 0) ? BIT_TICKS / 2 : 1;
    localparam int CW         = $clog2(BIT_TICKS + 1);

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic rx_s;
    logic rx_fall;

    assign rx_s    = sync_q[1];
    assign rx_fall = rx_prev_q & ~rx_s;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value; blocking here would chain the flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CW'(HALF_TICKS - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line back high by mid-start-bit was a glitch, not a frame.
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(BIT_TICKS - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(BIT_TICKS - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) valid_d = 1'b1;
                    else      err_d   = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_out   = shift_q;
    assign byte_valid = valid_q;
    assign stop_error = err_q;

endmodule

// File: rtl/rom_loader.sv
// Boot ROM filled over UART: A5, word count, little-endian words; releases the CPU when complete.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [7:0]  rom_address,
    output logic [31:0] rom_data,
    output logic        cpu_enable,
    output logic        loading,
    output logic        frame_error
);

    localparam int BIT_TICKS = CLK_HZ / BAUD;
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_stop_err;

    uart_rx #(
        .BIT_TICKS(BIT_TICKS)
    ) u_uart_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (uart_rx),
        .byte_out  (rx_byte),
        .byte_valid(rx_valid),
        .stop_error(rx_stop_err)
    );

    load_state_e state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  word_ptr_q, word_ptr_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic        wr_pend_q, wr_pend_d;
    logic        cpu_enable_q, cpu_enable_d;
    logic        frame_error_q, frame_error_d;
    logic        wr_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= WAIT_HDR;
            count_q       <= '0;
            word_ptr_q    <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            wr_pend_q     <= 1'b0;
            cpu_enable_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            word_ptr_q    <= word_ptr_d;
            byte_idx_q    <= byte_idx_d;
            asm_q         <= asm_d;
            wr_pend_q     <= wr_pend_d;
            cpu_enable_q  <= cpu_enable_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        word_ptr_d    = word_ptr_q;
        byte_idx_d    = byte_idx_q;
        asm_d         = asm_q;
        wr_pend_d     = 1'b0;
        frame_error_d = frame_error_q;

        unique case (state_q)
            WAIT_HDR: begin
                if (rx_valid && rx_byte == HDR_BYTE) state_d = GET_COUNT;
            end
            GET_COUNT: begin
                if (rx_valid) begin
                    count_d    = rx_byte;
                    word_ptr_d = '0;
                    byte_idx_d = '0;
                    state_d    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    asm_d = {rx_byte, asm_q[31:8]};
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = '0;
                        wr_pend_d  = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
                // The word is written the cycle after its 4th byte; the pointer advances with it.
                if (wr_pend_q) begin
                    word_ptr_d = word_ptr_q + 8'd1;
                    if (is_last_word(word_ptr_q, count_q)) state_d = RUN;
                end
            end
            RUN: begin
                if (rx_valid && rx_byte == HDR_BYTE) state_d = GET_COUNT;
            end
            default: state_d = WAIT_HDR;
        endcase

        if (rx_stop_err) begin
            state_d       = WAIT_HDR;
            frame_error_d = 1'b1;
            wr_pend_d     = 1'b0;
        end
    end

    assign cpu_enable_d = (state_d == RUN);
    assign wr_en        = wr_pend_q && (state_q == GET_DATA) && rst;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;

    // NOTE: the array and its read register carry no reset so they map onto
    // block RAM; the program image must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) mem[word_ptr_q[AW-1:0]] <= asm_q;
        rd_q <= mem[rom_address[AW-1:0]];
    end

    assign rom_data    = cpu_enable_q ? rd_q : NOP_WORD;
    assign cpu_enable  = cpu_enable_q;
    assign loading     = (state_q == GET_COUNT) || (state_q == GET_DATA);
    assign frame_error = frame_error_q;

endmodule
